mix_column_engine: RTL and testbench

- Sequential, parametrised successor to the combinational AES MixColumns/InvMixColumns block.
- Processes one 128-bit state word through MixColumns when encrypt=1, or InvMixColumns when encrypt=0, computing LANES columns per clock.
- Uses a valid/ready handshake on both sides and sits between the ShiftRows and AddRoundKey stages of the round datapath.
- Holds its result until the downstream stage accepts it.

---
 rtl/mix_column_engine.sv | 158 +++++++++++++++
 tb/tb_mix_column_engine.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mix_column_engine.sv
// rtl/mix_column_engine.sv - sequential AES MixColumns/InvMixColumns engine, LANES columns per clock
// Optional feature macro: MIXCOL_BYPASS_EN (adds bypass input for the final round).
module mix_column_engine #(
  parameter int LANES = 4,
  parameter int CNT_W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         encrypt,
`ifdef MIXCOL_BYPASS_EN
  input  logic         bypass,
`endif
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  localparam int GROUPS = 4 / LANES;
  localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(GROUPS - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $error("mix_column_engine: LANES must be 1, 2 or 4");
  end
  if ((1 << CNT_W) < GROUPS) begin : g_bad_cnt
    $error("mix_column_engine: CNT_W too narrow for 4/LANES groups");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_grp;
  logic [127:0]       r_in;
  logic               r_enc;
  logic [127:0]       r_res;
  logic [127:0]       w_res_next;
  logic               w_accept;
  logic               w_bypass;
  logic [31:0]        w_lane_in  [LANES];
  logic [31:0]        w_lane_out [LANES];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Coefficients are at most 0x0E, so four shift-and-add steps suffice.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 4; i++) begin
      if (c[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic enc);
    logic [7:0]  a [4];
    logic [3:0]  m [4];
    logic [7:0]  b;
    logic [31:0] res;
    if (enc) begin
      m[0] = 4'h2; m[1] = 4'h3; m[2] = 4'h1; m[3] = 4'h1;
    end else begin
      m[0] = 4'he; m[1] = 4'hb; m[2] = 4'hd; m[3] = 4'h9;
    end
    for (int k = 0; k < 4; k++) a[k] = col[31-8*k -: 8];
    res = 32'h0;
    for (int r = 0; r < 4; r++) begin
      b = 8'h00;
      for (int k = 0; k < 4; k++) b = b ^ gmul(a[k], m[(k - r) & 3]);
      res[31-8*r -: 8] = b;
    end
    return res;
  endfunction

`ifdef MIXCOL_BYPASS_EN
  assign w_bypass = bypass;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_accept = (r_state == S_IDLE) && in_valid;

  // Only LANES mixers exist; each picks its column of the current group.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_lane_in[l] = 32'h0;
      for (int g = 0; g < GROUPS; g++) begin
        if (r_grp == CNT_W'(g)) w_lane_in[l] = r_in[127-32*(g*LANES+l) -: 32];
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_lane_out[l] = mix_col(w_lane_in[l], r_enc);
  end

  always_comb begin
    w_res_next = r_res;
    for (int c = 0; c < 4; c++) begin
      if (r_grp == CNT_W'(c / LANES)) w_res_next[127-32*c -: 32] = w_lane_out[c % LANES];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = w_bypass ? S_DONE : S_BUSY;
      S_BUSY:  if (r_grp == LAST_GRP) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE) && rst_n;
    out_valid = (r_state == S_DONE);
    busy      = (r_state == S_BUSY);
    state_out = r_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in  <= 128'h0;
      r_enc <= 1'b0;
      r_res <= 128'h0;
      r_grp <= '0;
    end else if (w_accept) begin
      r_in  <= state_in;
      r_enc <= encrypt;
      r_grp <= '0;
      if (w_bypass) r_res <= state_in;
    end else if (r_state == S_BUSY) begin
      r_res <= w_res_next;
      r_grp <= r_grp + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mix_column_engine.sv
// tb/tb_mix_column_engine.sv - directed bench for mix_column_engine at LANES=4, 2 and 1
module tb_mix_column_engine;

  typedef struct {
    logic         e;
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         iv   [3];
  logic         ir   [3];
  logic         enc  [3];
  logic         byp  [3];
  logic [127:0] sin  [3];
  logic         ov   [3];
  logic         ordy [3];
  logic [127:0] sout [3];
  logic         bsy  [3];

  int checks;
  int errors;
  int lanes_of [3];

  mix_column_engine #(.LANES(4), .CNT_W(2)) u_l4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .encrypt(enc[0]),
`ifdef MIXCOL_BYPASS_EN
    .bypass(byp[0]),
`endif
    .state_in(sin[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .state_out(sout[0]), .busy(bsy[0])
  );

  mix_column_engine #(.LANES(2), .CNT_W(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .encrypt(enc[1]),
`ifdef MIXCOL_BYPASS_EN
    .bypass(byp[1]),
`endif
    .state_in(sin[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .state_out(sout[1]), .busy(bsy[1])
  );

  mix_column_engine #(.LANES(1), .CNT_W(2)) u_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .encrypt(enc[2]),
`ifdef MIXCOL_BYPASS_EN
    .bypass(byp[2]),
`endif
    .state_in(sin[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .state_out(sout[2]), .busy(bsy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Full handshake with out_ready held high; lat counts edges after the accept edge.
  task automatic xfer(input int k, input logic e, input logic [127:0] din, input logic b,
                      output logic [127:0] dout, output int lat, output int busy_cycles);
    @(negedge clk);
    iv[k]   = 1'b1;
    enc[k]  = e;
    sin[k]  = din;
    byp[k]  = b;
    ordy[k] = 1'b1;
    @(posedge clk);
    #1;
    iv[k]  = 1'b0;
    sin[k] = ~din;
    enc[k] = ~e;
    byp[k] = ~b;
    lat = 0;
    busy_cycles = bsy[k] ? 1 : 0;
    while (!ov[k] && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (bsy[k]) busy_cycles++;
    end
    dout = sout[k];
    @(posedge clk);
    #1;
    ordy[k] = 1'b0;
    byp[k]  = 1'b0;
    chk($sformatf("ready_after_done[%0d]", k), {127'h0, ir[k]}, 128'h1);
    chk($sformatf("valid_after_done[%0d]", k), {127'h0, ov[k]}, 128'h0);
  endtask

  initial begin
    vec_t         vecs [7];
    logic [127:0] d, c, r;
    int           lat, lat2, bc;

    checks = 0;
    errors = 0;
    lanes_of[0] = 4; lanes_of[1] = 2; lanes_of[2] = 1;

    vecs[0] = '{1'b1, 128'hdb135345_01010101_01010101_01010101, 128'h8e4da1bc_01010101_01010101_01010101};
    vecs[1] = '{1'b0, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'hdb135345_f20a225c_01010101_c6c6c6c6};
    vecs[2] = '{1'b1, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 128'h046681e5_e0cb199a_48f8d37a_2806264c};
    vecs[3] = '{1'b0, 128'h046681e5_e0cb199a_48f8d37a_2806264c, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5};
    vecs[4] = '{1'b1, 128'hd4d4d4d5_2d26314c_c6c6c6c6_f20a225c, 128'hd5d5d7d6_4d7ebdf8_c6c6c6c6_9fdc589d};
    vecs[5] = '{1'b0, 128'hd5d5d7d6_4d7ebdf8_c6c6c6c6_9fdc589d, 128'hd4d4d4d5_2d26314c_c6c6c6c6_f20a225c};
    vecs[6] = '{1'b1, 128'h0, 128'h0};

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; enc[k] = 1'b0; byp[k] = 1'b0; sin[k] = 128'h0; ordy[k] = 1'b0;
    end
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("ready_in_reset[%0d]", k), {127'h0, ir[k]}, 128'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_ready[%0d]", k), {127'h0, ir[k]}, 128'h1);
      chk($sformatf("rst_valid[%0d]", k), {127'h0, ov[k]}, 128'h0);
      chk($sformatf("rst_busy[%0d]", k), {127'h0, bsy[k]}, 128'h0);
      chk($sformatf("rst_state_out[%0d]", k), sout[k], 128'h0);
    end

    for (int v = 0; v < 7; v++) begin
      for (int k = 0; k < 3; k++) begin
        xfer(k, vecs[v].e, vecs[v].din, 1'b0, r, lat, bc);
        chk($sformatf("vec%0d_lanes%0d_data", v, lanes_of[k]), r, vecs[v].exp);
        chk($sformatf("vec%0d_lanes%0d_latency", v, lanes_of[k]), 128'(lat), 128'(4 / lanes_of[k]));
        chk($sformatf("vec%0d_lanes%0d_busy", v, lanes_of[k]), 128'(bc), 128'(4 / lanes_of[k]));
      end
    end

    // Backpressure: result held, new in_valid data must not be captured.
    @(negedge clk);
    iv[0] = 1'b1; enc[0] = 1'b1; sin[0] = vecs[0].din; ordy[0] = 1'b0;
    @(posedge clk);
    #1;
    sin[0] = vecs[2].din;
    enc[0] = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_data[%0d]", i), sout[0], vecs[0].exp);
      chk($sformatf("bp_ready[%0d]", i), {127'h0, ir[0]}, 128'h0);
      chk($sformatf("bp_valid[%0d]", i), {127'h0, ov[0]}, 128'h1);
    end
    @(negedge clk);
    ordy[0] = 1'b1;
    iv[0]   = 1'b0;
    @(posedge clk);
    #1;
    ordy[0] = 1'b0;
    chk("bp_release_valid", {127'h0, ov[0]}, 128'h0);
    chk("bp_release_ready", {127'h0, ir[0]}, 128'h1);
    @(posedge clk);
    #1;
    chk("bp_no_capture_busy", {127'h0, bsy[0]}, 128'h0);
    chk("bp_no_capture_valid", {127'h0, ov[0]}, 128'h0);
    chk("bp_result_kept", sout[0], vecs[0].exp);

    // Reset in the middle of BUSY on the LANES=1 engine (grp=2).
    @(negedge clk);
    iv[2] = 1'b1; enc[2] = 1'b0; sin[2] = vecs[1].din; ordy[2] = 1'b0;
    @(posedge clk);
    #1;
    iv[2] = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("mid_busy_precondition", {127'h0, bsy[2]}, 128'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {127'h0, ov[2]}, 128'h0);
    chk("mid_rst_busy", {127'h0, bsy[2]}, 128'h0);
    chk("mid_rst_state_out", sout[2], 128'h0);
    chk("mid_rst_ready", {127'h0, ir[2]}, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    xfer(2, 1'b0, vecs[1].din, 1'b0, r, lat, bc);
    chk("post_rst_data", r, vecs[1].exp);
    chk("post_rst_latency", 128'(lat), 128'd4);

    // Round trip on LANES=2.
    for (int n = 0; n < 1000; n++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      xfer(1, 1'b1, d, 1'b0, c, lat, bc);
      xfer(1, 1'b0, c, 1'b0, r, lat2, bc);
      chk($sformatf("roundtrip[%0d]", n), r, d);
      chk($sformatf("roundtrip_lat_enc[%0d]", n), 128'(lat), 128'd2);
      chk($sformatf("roundtrip_lat_dec[%0d]", n), 128'(lat2), 128'd2);
    end

`ifdef MIXCOL_BYPASS_EN
    for (int k = 0; k < 3; k += 2) begin
      xfer(k, 1'b1, 128'h00112233445566778899aabbccddeeff, 1'b1, r, lat, bc);
      chk($sformatf("bypass_data[%0d]", k), r, 128'h00112233445566778899aabbccddeeff);
      chk($sformatf("bypass_latency[%0d]", k), 128'(lat), 128'd0);
      chk($sformatf("bypass_busy[%0d]", k), 128'(bc), 128'd0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
